// File: rtl/spike_dispatcher.sv
// Spike dispatcher: drains a FIFO of neuron addresses and issues each one as a four-phase AER event.
// Optional saturating event counter, enabled by defining SPIKE_DISPATCH_EVCNT_EN.
module spike_dispatcher #(
    parameter int unsigned N           = 256,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 enable_i,
    input  logic                 FIFO_empty_i,
    input  logic [$clog2(N)-1:0] FIFO_r_data_i,
    output logic                 FIFO_r_en_o,
    output logic [$clog2(N)-1:0] AERIN_ADDR_o,
    output logic                 AERIN_REQ_o,
    input  logic                 AERIN_ACK_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_err_o
`ifdef SPIKE_DISPATCH_EVCNT_EN
    ,
    output logic [15:0]          event_count_o
`endif
);

    localparam int unsigned AW          = $clog2(N);
    localparam logic [16:0] TIMEOUT_LIM = 17'(ACK_TIMEOUT);

    typedef enum logic [2:0] {StIdle, StPop, StLatch, StReq, StAckLo} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic            r_req;
    logic            r_done;
    logic            r_timeout;
    logic [15:0]     r_wait_cnt;

    logic [16:0]     w_wait_inc;
    logic            w_timeout_hit;
    logic            w_acklo_exit;

    // One extra bit so ACK_TIMEOUT = 65535 cannot wrap the compare.
    assign w_wait_inc    = {1'b0, r_wait_cnt} + 17'd1;
    assign w_timeout_hit = (r_state == StReq) && !AERIN_ACK_i && (w_wait_inc >= TIMEOUT_LIM);
    assign w_acklo_exit  = (r_state == StAckLo) && !AERIN_ACK_i;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                // Never pop while the previous acknowledge is still high.
                StIdle: begin
                    if (enable_i && !FIFO_empty_i && !AERIN_ACK_i) begin
                        r_state <= StPop;
                    end
                end
                StPop: begin
                    r_state <= StLatch;
                end
                StLatch: begin
                    r_addr     <= FIFO_r_data_i;
                    r_wait_cnt <= '0;
                    r_req      <= 1'b1;
                    r_state    <= StReq;
                end
                StReq: begin
                    if (AERIN_ACK_i) begin
                        r_req   <= 1'b0;
                        r_state <= StAckLo;
                    end else if (w_timeout_hit) begin
                        r_req      <= 1'b0;
                        r_timeout  <= 1'b1;
                        r_wait_cnt <= w_wait_inc[15:0];
                        r_state    <= StAckLo;
                    end else begin
                        r_wait_cnt <= w_wait_inc[15:0];
                    end
                end
                StAckLo: begin
                    if (w_acklo_exit) begin
                        r_done  <= FIFO_empty_i;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign FIFO_r_en_o   = (r_state == StPop);
    assign busy_o        = (r_state != StIdle);
    assign AERIN_ADDR_o  = r_addr;
    assign AERIN_REQ_o   = r_req;
    assign done_o        = r_done;
    assign timeout_err_o = r_timeout;

`ifdef SPIKE_DISPATCH_EVCNT_EN
    logic        r_enable_prev;
    logic        r_timed_out;
    logic [15:0] r_event_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_enable_prev <= 1'b0;
            r_timed_out   <= 1'b0;
            r_event_cnt   <= '0;
        end else begin
            r_enable_prev <= enable_i;
            // Remembers whether the event currently in flight ended by timeout.
            if (r_state == StLatch) begin
                r_timed_out <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timed_out <= 1'b1;
            end
            if (enable_i && !r_enable_prev) begin
                r_event_cnt <= '0;
            end else if (w_acklo_exit && !r_timed_out && (r_event_cnt != 16'hFFFF)) begin
                r_event_cnt <= r_event_cnt + 16'd1;
            end
        end
    end

    assign event_count_o = r_event_cnt;
`endif

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: FIFO model, AER responder and an address scoreboard.
module tb_spike_dispatcher;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        enable_i = 1'b0;
    logic        FIFO_empty_i = 1'b1;
    logic [7:0]  FIFO_r_data_i = 8'd0;
    logic        FIFO_r_en_o;
    logic [7:0]  AERIN_ADDR_o;
    logic        AERIN_REQ_o;
    logic        AERIN_ACK_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        timeout_err_o;
`ifdef SPIKE_DISPATCH_EVCNT_EN
    logic [15:0] event_count_o;
`endif

    spike_dispatcher #(
        .N           (256),
        .ACK_TIMEOUT (10)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .enable_i      (enable_i),
        .FIFO_empty_i  (FIFO_empty_i),
        .FIFO_r_data_i (FIFO_r_data_i),
        .FIFO_r_en_o   (FIFO_r_en_o),
        .AERIN_ADDR_o  (AERIN_ADDR_o),
        .AERIN_REQ_o   (AERIN_REQ_o),
        .AERIN_ACK_i   (AERIN_ACK_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .timeout_err_o (timeout_err_o)
`ifdef SPIKE_DISPATCH_EVCNT_EN
        ,
        .event_count_o (event_count_o)
`endif
    );

    always #5 CLK = ~CLK;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         pops = 0;
    int         pop_cyc = 0;
    int         done_cnt = 0;
    int         req_len = 0;
    int         last_req_len = 0;
    int         req_cycles = 0;
    int         ack_delay = 2;
    logic       ack_block = 1'b0;
    logic       req_prev = 1'b0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // FIFO model: head data appears the cycle after the pop strobe.
    always @(posedge CLK) begin
        if (FIFO_r_en_o && (fifo_q.size() > 0)) begin
            FIFO_r_data_i <= fifo_q.pop_front();
            pops <= pops + 1;
        end
        FIFO_empty_i <= (fifo_q.size() == 0);
    end

    // Monitor first, then the neuron-core responder, in one process to fix their order.
    always @(negedge CLK) begin
        logic [7:0] e;
        if (!RST) begin
            if (FIFO_r_en_o) begin
                pop_cyc = cyc;
                check("pop_nonempty", 32'(FIFO_empty_i), 0);
                check("pop_ack_low", 32'(AERIN_ACK_i), 0);
            end
            if (AERIN_REQ_o && !req_prev) begin
                check("req_ack_low", 32'(AERIN_ACK_i), 0);
                check("req_latency", 32'(cyc - pop_cyc), 2);
                check("req_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("req_addr", 32'(AERIN_ADDR_o), 32'(e));
                end
                req_len = 0;
            end
            if (AERIN_REQ_o) req_len++;
            if (!AERIN_REQ_o && req_prev) last_req_len = req_len;
            if (done_o) done_cnt++;
        end
        req_prev = AERIN_REQ_o;
        if (AERIN_REQ_o && !ack_block) begin
            req_cycles++;
            if (req_cycles >= ack_delay) AERIN_ACK_i = 1'b1;
        end else if (!AERIN_REQ_o) begin
            req_cycles = 0;
            AERIN_ACK_i = 1'b0;
        end
    end

    task automatic push(input logic [7:0] v, input logic expect_req);
        fifo_q.push_back(v);
        if (expect_req) exp_q.push_back(v);
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(((fifo_q.size() == 0) || !enable_i) && !busy_o && !AERIN_ACK_i) && (n < budget));
        check("quiet_bound", 32'(n < budget), 1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!AERIN_REQ_o && (n < budget)) begin
            @(negedge CLK);
            n++;
        end
        check("req_bound", 32'(n < budget), 1);
    endtask

    initial begin
        int p0;
        int d0;
        int flag;

        #1 RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_req", 32'(AERIN_REQ_o), 0);
        check("rst_addr", 32'(AERIN_ADDR_o), 0);
        check("rst_ren", 32'(FIFO_r_en_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_tmo", 32'(timeout_err_o), 0);
        RST = 1'b0;
        @(negedge CLK);

        // Single event, ACK after two REQ cycles.
        p0 = pops; d0 = done_cnt;
        push(8'd5, 1'b1);
        enable_i = 1'b1;
        wait_quiet(100);
        check("t1_pops", 32'(pops - p0), 1);
        check("t1_done", 32'(done_cnt - d0), 1);
        check("t1_reqlen", 32'(last_req_len), 2);
        check("t1_addr_hold", 32'(AERIN_ADDR_o), 5);
        check("t1_sb_empty", 32'(exp_q.size()), 0);
        enable_i = 1'b0;
        @(negedge CLK);

        // Three back-to-back events.
        p0 = pops; d0 = done_cnt;
        push(8'd1, 1'b1); push(8'd200, 1'b1); push(8'd255, 1'b1);
        enable_i = 1'b1;
        wait_quiet(200);
        check("t2_pops", 32'(pops - p0), 3);
        check("t2_done", 32'(done_cnt - d0), 1);
        check("t2_addr_last", 32'(AERIN_ADDR_o), 255);
        check("t2_sb_empty", 32'(exp_q.size()), 0);
`ifdef SPIKE_DISPATCH_EVCNT_EN
        check("t2_evcnt", 32'(event_count_o), 3);
`endif
        enable_i = 1'b0;
        @(negedge CLK);

        // ACK already present in the first REQ cycle.
        ack_delay = 1;
        push(8'd42, 1'b1);
        enable_i = 1'b1;
        wait_quiet(100);
        check("t3_reqlen", 32'(last_req_len), 1);
        check("t3_tmo", 32'(timeout_err_o), 0);
        ack_delay = 2;
        enable_i = 1'b0;
        @(negedge CLK);

        // Timeout: one good event, then ACK withheld.
        enable_i = 1'b1;
        push(8'd3, 1'b1);
        wait_quiet(100);
        ack_block = 1'b1;
        push(8'd9, 1'b1);
        wait_quiet(200);
        check("t4_reqlen", 32'(last_req_len), 10);
        check("t4_tmo", 32'(timeout_err_o), 1);
`ifdef SPIKE_DISPATCH_EVCNT_EN
        check("t4_evcnt", 32'(event_count_o), 1);
`endif
        ack_block = 1'b0;
        push(8'd11, 1'b1);
        wait_quiet(100);
        check("t4_tmo_sticky", 32'(timeout_err_o), 1);
        check("t4_reqlen2", 32'(last_req_len), 2);
`ifdef SPIKE_DISPATCH_EVCNT_EN
        check("t4_evcnt2", 32'(event_count_o), 2);
`endif
        enable_i = 1'b0;
        @(negedge CLK);

        // enable_i drops mid-event: event 7 finishes, 8 stays queued.
        p0 = pops;
        push(8'd7, 1'b1); push(8'd8, 1'b0);
        enable_i = 1'b1;
        wait_req(50);
        enable_i = 1'b0;
        wait_quiet(100);
        repeat (5) @(negedge CLK);
        check("t5_pops", 32'(pops - p0), 1);
        check("t5_busy", 32'(busy_o), 0);
        check("t5_left", 32'(fifo_q.size()), 1);
        check("t5_addr", 32'(AERIN_ADDR_o), 7);
        fifo_q.delete();
        repeat (2) @(negedge CLK);

        // Asynchronous reset mid-handshake.
        push(8'd50, 1'b1);
        enable_i = 1'b1;
        wait_req(50);
        #2 RST = 1'b1;
        #1;
        check("t6_req", 32'(AERIN_REQ_o), 0);
        check("t6_busy", 32'(busy_o), 0);
        check("t6_addr", 32'(AERIN_ADDR_o), 0);
        check("t6_tmo", 32'(timeout_err_o), 0);
        p0 = pops;
        push(8'd60, 1'b1);
        repeat (4) @(negedge CLK);
        check("t6_no_pop", 32'(pops - p0), 0);
        check("t6_ren", 32'(FIFO_r_en_o), 0);
        RST = 1'b0;
        wait_quiet(100);
        check("t6_after_pops", 32'(pops - p0), 1);
        check("t6_after_addr", 32'(AERIN_ADDR_o), 60);

        // Empty FIFO with enable high: nothing may happen.
        flag = 0;
        enable_i = 1'b1;
        repeat (100) begin
            @(negedge CLK);
            if (FIFO_r_en_o || AERIN_REQ_o || done_o) flag++;
        end
        check("t7_idle", 32'(flag), 0);
        check("t7_sb_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
